// File: rtl/gpu_mem_pkg.sv
// Shared types and default widths for the LSU-to-memory arbiter.
package gpu_mem_pkg;

    localparam int DEFAULT_ADDR_BITS = 8;
    localparam int DEFAULT_DATA_BITS = 8;

    typedef enum logic [2:0] {
        CH_IDLE           = 3'd0,
        CH_READ_WAITING   = 3'd1,
        CH_WRITE_WAITING  = 3'd2,
        CH_READ_RELAYING  = 3'd3,
        CH_WRITE_RELAYING = 3'd4
    } ch_state_t;

    function automatic int index_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Consumer-side and memory-side buses of the arbiter; slave is the arbiter's view.
interface mem_arbiter_if
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output mem_read_valid, mem_read_address,
        input  mem_read_ready, mem_read_data,
        output mem_write_valid, mem_write_address, mem_write_data,
        input  mem_write_ready
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        output mem_read_ready, mem_read_data,
        input  mem_write_valid, mem_write_address, mem_write_data,
        output mem_write_ready
    );

endinterface

// File: rtl/mem_channel.sv
// One external memory channel: captures a granted request, waits on memory,
// then relays completion to the owning consumer until it drops its valid.
module mem_channel
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int NUM_CONSUMERS = 4,
    parameter int WRITE_ENABLE  = 1,
    localparam int CW           = index_bits(NUM_CONSUMERS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 grant,
    input  logic                 grant_write,
    input  logic [CW-1:0]        grant_consumer,
    input  logic [ADDR_BITS-1:0] grant_address,
    input  logic [DATA_BITS-1:0] grant_data,
    input  logic                 owner_valid,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    input  logic                 mem_write_ready,
    output ch_state_t            state,
    output logic [CW-1:0]        owner,
    output logic                 release_claim,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    output logic [DATA_BITS-1:0] read_data
);
    ch_state_t            state_reg, state_next;
    logic [CW-1:0]        owner_reg;
    logic [ADDR_BITS-1:0] rd_addr_reg;
    logic [DATA_BITS-1:0] rd_data_reg;
    logic                 take_grant;

    assign take_grant = (state_reg == CH_IDLE) && grant;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CH_IDLE:
                if (grant)
                    state_next = (grant_write && WRITE_ENABLE != 0) ? CH_WRITE_WAITING
                                                                     : CH_READ_WAITING;
            CH_READ_WAITING:   if (mem_read_ready)  state_next = CH_READ_RELAYING;
            CH_WRITE_WAITING:  if (mem_write_ready) state_next = CH_WRITE_RELAYING;
            CH_READ_RELAYING,
            CH_WRITE_RELAYING: if (!owner_valid)    state_next = CH_IDLE;
            default:                                state_next = CH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= CH_IDLE;
            owner_reg   <= '0;
            rd_addr_reg <= '0;
            rd_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (take_grant)
                owner_reg <= grant_consumer;
            if (take_grant && !grant_write)
                rd_addr_reg <= grant_address;
            if (state_reg == CH_READ_WAITING && mem_read_ready)
                rd_data_reg <= mem_read_data;
        end
    end

    assign state            = state_reg;
    assign owner            = owner_reg;
    assign release_claim    = ((state_reg == CH_READ_RELAYING) || (state_reg == CH_WRITE_RELAYING))
                              && !owner_valid;
    assign mem_read_valid   = (state_reg == CH_READ_WAITING);
    assign mem_read_address = rd_addr_reg;
    assign read_data        = rd_data_reg;

    generate
        if (WRITE_ENABLE != 0) begin : g_write
            logic [ADDR_BITS-1:0] wr_addr_reg;
            logic [DATA_BITS-1:0] wr_data_reg;

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_addr_reg <= '0;
                    wr_data_reg <= '0;
                end else if (take_grant && grant_write) begin
                    wr_addr_reg <= grant_address;
                    wr_data_reg <= grant_data;
                end
            end

            assign mem_write_valid   = (state_reg == CH_WRITE_WAITING);
            assign mem_write_address = wr_addr_reg;
            assign mem_write_data    = wr_data_reg;
        end else begin : g_no_write
            logic unused_write_inputs;
            assign unused_write_inputs = ^grant_data;
            assign mem_write_valid     = 1'b0;
            assign mem_write_address   = '0;
            assign mem_write_data      = '0;
        end
    endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter mapping LSU consumers onto a pool of memory channels;
// the claim mask keeps any consumer owned by at most one channel.
module mem_arbiter
    import gpu_mem_pkg::*;
#(
    parameter int ADDR_BITS     = DEFAULT_ADDR_BITS,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2,
    parameter int WRITE_ENABLE  = 1
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int CW = index_bits(NUM_CONSUMERS);

    logic [NUM_CONSUMERS-1:0]               claim_reg, claim_next;
    logic [NUM_CHANNELS-1:0]                grant, grant_write;
    logic [NUM_CHANNELS-1:0][CW-1:0]        grant_consumer;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] grant_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] grant_data;

    ch_state_t     ch_state [NUM_CHANNELS];
    logic [CW-1:0] ch_owner [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                ch_release, ch_owner_valid;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_read_data;

    logic [NUM_CHANNELS-1:0]                mem_read_valid_w, mem_write_valid_w;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address_w, mem_write_address_w;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data_w;

    logic [NUM_CONSUMERS-1:0]                read_ready_w, write_ready_w;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] read_data_w;

    // Channels scan in ascending order; a consumer taken by a lower channel
    // this cycle is hidden from the higher ones. Reads win over writes.
    always_comb begin : arbitrate
        logic [NUM_CONSUMERS-1:0] taken;
        logic                     found;
        taken          = claim_reg;
        grant          = '0;
        grant_write    = '0;
        grant_consumer = '0;
        grant_address  = '0;
        grant_data     = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            found = 1'b0;
            if (ch_state[ch] == CH_IDLE) begin
                for (int c = 0; c < NUM_CONSUMERS; c++) begin
                    if (!found && !taken[c] &&
                        (bus.consumer_read_valid[c] ||
                         (WRITE_ENABLE != 0 && bus.consumer_write_valid[c]))) begin
                        found              = 1'b1;
                        taken[c]           = 1'b1;
                        grant[ch]          = 1'b1;
                        grant_consumer[ch] = CW'(c);
                        grant_write[ch]    = !bus.consumer_read_valid[c];
                        grant_address[ch]  = bus.consumer_read_valid[c] ? bus.consumer_read_address[c]
                                                                        : bus.consumer_write_address[c];
                        grant_data[ch]     = bus.consumer_write_data[c];
                    end
                end
            end
        end
    end

    always_comb begin
        claim_next    = claim_reg;
        read_ready_w  = '0;
        write_ready_w = '0;
        read_data_w   = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (ch_release[ch])
                claim_next[ch_owner[ch]] = 1'b0;
            if (grant[ch])
                claim_next[grant_consumer[ch]] = 1'b1;
            if (ch_state[ch] == CH_READ_RELAYING) begin
                read_ready_w[ch_owner[ch]] = 1'b1;
                read_data_w[ch_owner[ch]]  = ch_read_data[ch];
            end
            if (ch_state[ch] == CH_WRITE_RELAYING)
                write_ready_w[ch_owner[ch]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            claim_reg <= '0;
        else
            claim_reg <= claim_next;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_channel
            assign ch_owner_valid[gi] = (ch_state[gi] == CH_WRITE_RELAYING)
                                        ? bus.consumer_write_valid[ch_owner[gi]]
                                        : bus.consumer_read_valid[ch_owner[gi]];

            mem_channel #(
                .ADDR_BITS     (ADDR_BITS),
                .DATA_BITS     (DATA_BITS),
                .NUM_CONSUMERS (NUM_CONSUMERS),
                .WRITE_ENABLE  (WRITE_ENABLE)
            ) u_channel (
                .clk               (clk),
                .reset             (reset),
                .grant             (grant[gi]),
                .grant_write       (grant_write[gi]),
                .grant_consumer    (grant_consumer[gi]),
                .grant_address     (grant_address[gi]),
                .grant_data        (grant_data[gi]),
                .owner_valid       (ch_owner_valid[gi]),
                .mem_read_ready    (bus.mem_read_ready[gi]),
                .mem_read_data     (bus.mem_read_data[gi]),
                .mem_write_ready   (bus.mem_write_ready[gi]),
                .state             (ch_state[gi]),
                .owner             (ch_owner[gi]),
                .release_claim     (ch_release[gi]),
                .mem_read_valid    (mem_read_valid_w[gi]),
                .mem_read_address  (mem_read_address_w[gi]),
                .mem_write_valid   (mem_write_valid_w[gi]),
                .mem_write_address (mem_write_address_w[gi]),
                .mem_write_data    (mem_write_data_w[gi]),
                .read_data         (ch_read_data[gi])
            );
        end
    endgenerate

    assign bus.mem_read_valid       = mem_read_valid_w;
    assign bus.mem_read_address     = mem_read_address_w;
    assign bus.mem_write_valid      = mem_write_valid_w;
    assign bus.mem_write_address    = mem_write_address_w;
    assign bus.mem_write_data       = mem_write_data_w;
    assign bus.consumer_read_ready  = read_ready_w;
    assign bus.consumer_read_data   = read_data_w;
    assign bus.consumer_write_ready = write_ready_w;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one write-capable instance and one read-only instance.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) if0 ();
    mem_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) if1 ();

    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2),
                  .WRITE_ENABLE(1)) u_dut (.clk(clk), .reset(reset), .bus(if0));
    mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2),
                  .WRITE_ENABLE(0)) u_dut_nw (.clk(clk), .reset(reset), .bus(if1));

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        if0.consumer_read_valid = '0;    if0.consumer_read_address = '0;
        if0.consumer_write_valid = '0;   if0.consumer_write_address = '0;
        if0.consumer_write_data = '0;
        if0.mem_read_ready = '0;         if0.mem_read_data = '0;
        if0.mem_write_ready = '0;
        if1.consumer_read_valid = '0;    if1.consumer_read_address = '0;
        if1.consumer_write_valid = '0;   if1.consumer_write_address = '0;
        if1.consumer_write_data = '0;
        if1.mem_read_ready = '0;         if1.mem_read_data = '0;
        if1.mem_write_ready = '0;
        step(2);

        // Reset state
        check_value("rst_mem_rvalid", 32'(if0.mem_read_valid), 32'h0);
        check_value("rst_mem_wvalid", 32'(if0.mem_write_valid), 32'h0);
        check_value("rst_rready", 32'(if0.consumer_read_ready), 32'h0);
        check_value("rst_wready", 32'(if0.consumer_write_ready), 32'h0);
        check_value("rst_raddr", 32'(if0.mem_read_address), 32'h0);
        check_value("rst_claim", 32'(u_dut.claim_reg), 32'h0);
        reset = 1'b0;

        // Single read: consumer 2, addr 0x10, memory answers after 3 cycles
        if0.consumer_read_valid[2] = 1'b1;
        if0.consumer_read_address[2] = 8'h10;
        step();
        check_value("rd_mem_valid", 32'(if0.mem_read_valid), 32'h1);
        check_value("rd_mem_addr", 32'(if0.mem_read_address[0]), 32'h10);
        check_value("rd_claim", 32'(u_dut.claim_reg), 32'h4);
        step(2);
        if0.mem_read_ready[0] = 1'b1;
        if0.mem_read_data[0] = 8'hAB;
        step();
        if0.mem_read_ready[0] = 1'b0;
        check_value("rd_ready", 32'(if0.consumer_read_ready), 32'h4);
        check_value("rd_data", 32'(if0.consumer_read_data[2]), 32'hAB);
        check_value("rd_mem_valid_drop", 32'(if0.mem_read_valid), 32'h0);
        step(2);
        check_value("rd_ready_held", 32'(if0.consumer_read_ready), 32'h4);
        if0.consumer_read_valid[2] = 1'b0;
        step();
        check_value("rd_ready_clear", 32'(if0.consumer_read_ready), 32'h0);
        check_value("rd_claim_clear", 32'(u_dut.claim_reg), 32'h0);
        check_value("rd_ch0_idle", 32'(u_dut.ch_state[0]), 32'h0);

        // Single write: consumer 1 writes 0x55 to 0x20
        if0.consumer_write_valid[1] = 1'b1;
        if0.consumer_write_address[1] = 8'h20;
        if0.consumer_write_data[1] = 8'h55;
        step();
        check_value("wr_mem_valid", 32'(if0.mem_write_valid), 32'h1);
        check_value("wr_mem_addr", 32'(if0.mem_write_address[0]), 32'h20);
        check_value("wr_mem_data", 32'(if0.mem_write_data[0]), 32'h55);
        check_value("wr_no_read", 32'(if0.mem_read_valid), 32'h0);
        if0.mem_write_ready[0] = 1'b1;
        step();
        if0.mem_write_ready[0] = 1'b0;
        check_value("wr_ready", 32'(if0.consumer_write_ready), 32'h2);
        check_value("wr_mem_valid_drop", 32'(if0.mem_write_valid), 32'h0);
        if0.consumer_write_valid[1] = 1'b0;
        step();
        check_value("wr_ready_clear", 32'(if0.consumer_write_ready), 32'h0);
        check_value("wr_claim_clear", 32'(u_dut.claim_reg), 32'h0);

        // Contention: four readers, two channels
        for (int c = 0; c < 4; c++) begin
            if0.consumer_read_valid[c] = 1'b1;
            if0.consumer_read_address[c] = 8'(8'h30 + c);
        end
        step();
        check_value("ct_valid", 32'(if0.mem_read_valid), 32'h3);
        check_value("ct_addr0", 32'(if0.mem_read_address[0]), 32'h30);
        check_value("ct_addr1", 32'(if0.mem_read_address[1]), 32'h31);
        check_value("ct_claim", 32'(u_dut.claim_reg), 32'h3);
        if0.mem_read_ready[0] = 1'b1;
        if0.mem_read_data[0] = 8'hC0;
        step();
        if0.mem_read_ready[0] = 1'b0;
        check_value("ct_ready0", 32'(if0.consumer_read_ready), 32'h1);
        check_value("ct_data0", 32'(if0.consumer_read_data[0]), 32'hC0);
        if0.consumer_read_valid[0] = 1'b0;
        step();
        check_value("ct_release0", 32'(u_dut.claim_reg), 32'h2);
        step();
        check_value("ct_regrant_c2", 32'(if0.mem_read_address[0]), 32'h32);
        check_value("ct_claim_c2", 32'(u_dut.claim_reg), 32'h6);
        if0.mem_read_ready[1] = 1'b1;
        if0.mem_read_data[1] = 8'hC1;
        step();
        if0.mem_read_ready[1] = 1'b0;
        check_value("ct_ready1", 32'(if0.consumer_read_ready), 32'h2);
        check_value("ct_data1", 32'(if0.consumer_read_data[1]), 32'hC1);
        if0.consumer_read_valid[1] = 1'b0;
        step(2);
        check_value("ct_regrant_c3", 32'(if0.mem_read_address[1]), 32'h33);
        check_value("ct_claim_c3", 32'(u_dut.claim_reg), 32'hC);
        if0.mem_read_ready = 2'b11;
        if0.mem_read_data[0] = 8'hD2;
        if0.mem_read_data[1] = 8'hD3;
        step();
        if0.mem_read_ready = 2'b00;
        check_value("ct_ready23", 32'(if0.consumer_read_ready), 32'hC);
        check_value("ct_data23", {16'h0, if0.consumer_read_data[3], if0.consumer_read_data[2]}, 32'hD3D2);
        if0.consumer_read_valid = '0;
        step();
        check_value("ct_claim_end", 32'(u_dut.claim_reg), 32'h0);

        // Stall: memory withholds ready for 20 cycles while consumer address changes
        if0.consumer_read_valid[0] = 1'b1;
        if0.consumer_read_address[0] = 8'h44;
        step();
        if0.consumer_read_address[0] = 8'h99;
        for (int i = 0; i < 20; i++) begin
            step();
            check_value($sformatf("stall_%0d", i),
                        {15'h0, if0.consumer_read_ready, if0.mem_read_valid, if0.mem_read_address[0]},
                        32'h0000_0144);
        end
        if0.mem_read_ready[0] = 1'b1;
        if0.mem_read_data[0] = 8'h7E;
        step();
        if0.mem_read_ready[0] = 1'b0;
        check_value("stall_data", 32'(if0.consumer_read_data[0]), 32'h7E);
        if0.consumer_read_valid[0] = 1'b0;
        step();

        // Read and write together on one consumer: read first, then write
        if0.consumer_read_valid[0] = 1'b1;
        if0.consumer_read_address[0] = 8'h61;
        if0.consumer_write_valid[0] = 1'b1;
        if0.consumer_write_address[0] = 8'h62;
        if0.consumer_write_data[0] = 8'h63;
        step();
        check_value("rw_read_first", {30'h0, if0.mem_write_valid[0], if0.mem_read_valid[0]}, 32'h1);
        if0.mem_read_ready[0] = 1'b1;
        step();
        if0.mem_read_ready[0] = 1'b0;
        if0.consumer_read_valid[0] = 1'b0;
        step(2);
        check_value("rw_write_next", {30'h0, if0.mem_write_valid[0], if0.mem_read_valid[0]}, 32'h2);
        check_value("rw_write_addr", 32'(if0.mem_write_address[0]), 32'h62);
        if0.mem_write_ready[0] = 1'b1;
        step();
        if0.mem_write_ready[0] = 1'b0;
        check_value("rw_wready", 32'(if0.consumer_write_ready), 32'h1);
        if0.consumer_write_valid[0] = 1'b0;
        step();

        // Reset while READ_WAITING
        if0.consumer_read_valid[3] = 1'b1;
        if0.consumer_read_address[3] = 8'h55;
        step();
        check_value("rr_waiting", 32'(if0.mem_read_valid), 32'h1);
        reset = 1'b1;
        if0.consumer_read_valid[3] = 1'b0;
        step();
        reset = 1'b0;
        check_value("rr_valid", 32'(if0.mem_read_valid), 32'h0);
        check_value("rr_ready", 32'({if0.consumer_read_ready, if0.consumer_write_ready}), 32'h0);
        check_value("rr_claim", 32'(u_dut.claim_reg), 32'h0);
        if0.consumer_read_valid[1] = 1'b1;
        if0.consumer_read_address[1] = 8'h66;
        step();
        check_value("rr_new_addr", 32'(if0.mem_read_address[0]), 32'h66);
        if0.mem_read_ready[0] = 1'b1;
        if0.mem_read_data[0] = 8'h5A;
        step();
        if0.mem_read_ready[0] = 1'b0;
        check_value("rr_new_data", 32'(if0.consumer_read_data[1]), 32'h5A);
        check_value("rr_new_ready", 32'(if0.consumer_read_ready), 32'h2);
        if0.consumer_read_valid[1] = 1'b0;
        step();

        // Read-only instance: writes ignored, reads still served
        if1.consumer_write_valid[0] = 1'b1;
        if1.consumer_write_address[0] = 8'h12;
        if1.consumer_write_data[0] = 8'h34;
        if1.consumer_read_valid[1] = 1'b1;
        if1.consumer_read_address[1] = 8'h21;
        step();
        check_value("nw_wvalid", 32'(if1.mem_write_valid), 32'h0);
        check_value("nw_waddr_data", {16'h0, if1.mem_write_address[0], if1.mem_write_data[0]}, 32'h0);
        check_value("nw_rvalid", 32'(if1.mem_read_valid), 32'h1);
        check_value("nw_raddr", 32'(if1.mem_read_address[0]), 32'h21);
        if1.mem_read_ready[0] = 1'b1;
        if1.mem_read_data[0] = 8'h9C;
        if1.mem_write_ready = 2'b11;
        step();
        if1.mem_read_ready[0] = 1'b0;
        check_value("nw_rready", 32'(if1.consumer_read_ready), 32'h2);
        check_value("nw_rdata", 32'(if1.consumer_read_data[1]), 32'h9C);
        check_value("nw_wready", 32'(if1.consumer_write_ready), 32'h0);
        check_value("nw_wvalid_end", 32'({if1.mem_write_valid, if1.mem_write_address}), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 8, address width.
REQ-002 Parameter DATA_BITS, default 8, data width.
REQ-003 Parameter NUM_CONSUMERS, default 4, number of requesting LSUs.
REQ-004 Parameter NUM_CHANNELS, default 2, number of concurrent external memory channels.
REQ-005 Parameter WRITE_ENABLE, default 1; 0 removes all write logic and ties write outputs to 0.
REQ-006 Port clk, input, 1, single clock; all logic on rising edge.
REQ-007 Port reset, input, 1, synchronous, active-high reset.
REQ-008 Ports consumer_read_valid / consumer_read_address, input, [NUM_CONSUMERS] x 1 / x ADDR_BITS, LSU read request and address.
REQ-009 Ports consumer_read_ready / consumer_read_data, output, [NUM_CONSUMERS] x 1 / x DATA_BITS, read completion and data.
REQ-010 Ports consumer_write_valid / consumer_write_address / consumer_write_data, input, [NUM_CONSUMERS] x 1 / ADDR_BITS / DATA_BITS, LSU write request.
REQ-011 Port consumer_write_ready, output, [NUM_CONSUMERS] x 1, write completion.
REQ-012 Ports mem_read_valid / mem_read_address, output, [NUM_CHANNELS] x 1 / ADDR_BITS; mem_read_ready / mem_read_data, input, [NUM_CHANNELS] x 1 / DATA_BITS.
REQ-013 Ports mem_write_valid / mem_write_address / mem_write_data, output, [NUM_CHANNELS] x 1 / ADDR_BITS / DATA_BITS; mem_write_ready, input, [NUM_CHANNELS] x 1.

Function
REQ-014 Each channel SHALL run an FSM: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
REQ-015 A claim mask of NUM_CONSUMERS bits SHALL mark consumers currently owned by a channel; an owned consumer is never granted to a second channel.
REQ-016 IDLE channel: scan consumers from index 0 upward; first unclaimed consumer with read_valid or write_valid wins (fixed priority, lowest index).
REQ-017 Same-cycle grants: channels evaluated in ascending index; a consumer claimed by channel k in a cycle SHALL be invisible to channels >k that cycle.
REQ-018 If a consumer asserts read_valid and write_valid together, read SHALL be served first.
REQ-019 Read grant: next edge set mem_read_valid[ch]=1, mem_read_address[ch]=consumer address, claim bit=1, state READ_WAITING.
REQ-020 READ_WAITING: on mem_read_ready[ch]=1 set mem_read_valid[ch]=0, consumer_read_ready[c]=1, consumer_read_data[c]=mem_read_data[ch], state READ_RELAYING; otherwise hold indefinitely.
REQ-021 READ_RELAYING: hold consumer_read_ready[c]=1 until consumer_read_valid[c]=0; then on that edge clear ready, clear claim bit, return IDLE.
REQ-022 Write path SHALL mirror REQ-019..021 using mem_write_* and consumer_write_ready; address and data captured at grant.
REQ-023 Minimum round trip: grant edge, +1 mem valid visible, ready completes one edge after mem ready, release one edge after consumer drops valid; a released consumer is re-grantable next cycle.
REQ-024 Address/data SHALL be registered at grant and held stable while mem valid is high, regardless of consumer input changes.
REQ-025 With NUM_CONSUMERS <= NUM_CHANNELS every requesting consumer SHALL be granted within one cycle.

Reset
REQ-026 On reset all channels to IDLE; claim mask 0; all mem_*_valid, consumer_*_ready 0; all address/data outputs 0.
REQ-027 Reset mid-transaction SHALL abandon it without completion; mem valids drop on the reset edge.

Structure
REQ-028 Package gpu_mem_pkg SHALL hold the channel-state enum and default ADDR_BITS/DATA_BITS constants.
REQ-029 Per-channel FSM SHALL be sub-module mem_channel (inputs: grant, consumer index, request type; outputs: state, release); arbitration and claim mask remain in mem_arbiter.

Verification
REQ-030 Single read: consumer 2 reads addr 0x10, memory returns 0xAB after 3 cycles -> consumer_read_data[2]=0xAB with ready, ready held until valid drops, channel 0 IDLE.
REQ-031 Single write: consumer 1 writes 0x55 to 0x20 -> mem_write_address[0]=0x20, data 0x55, consumer_write_ready[1]=1 after mem_write_ready.
REQ-032 Contention: consumers 0-3 read simultaneously, 2 channels -> grants 0 on ch0, 1 on ch1; 2 and 3 served after releases; no consumer on two channels.
REQ-033 Stall: mem_read_ready held 0 for 20 cycles -> mem_read_valid and address stable throughout; no consumer ready.
REQ-034 Reset during READ_WAITING -> next cycle all valids/readies 0, claim mask 0; new request served normally.
REQ-035 WRITE_ENABLE=0 -> write valid from consumer ignored, all mem_write_* stay 0, reads unaffected.
